// File: rtl/baud_switch_ctrl.sv
// Run-time baud-select switcher: holds TX, waits for a quiet link, applies the new select, then settles.
// Optional DRAIN timeout with ABORT/err is enabled by defining BAUD_CTRL_TIMEOUT_EN.
module baud_switch_ctrl #(
    parameter logic [1:0] RESET_SEL      = 2'b00,
    parameter int         QUIET_CYCLES   = 16,
    parameter int         SETTLE_CYCLES  = 5208,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [1:0] req_sel,
    output logic       req_ready,
    input  logic       tx_busy,
    input  logic       rx_busy,
    output logic       hold,
    output logic [1:0] baud_sel,
    output logic       done,
    output logic       err
);

    localparam int QW = $clog2(QUIET_CYCLES + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
`ifdef BAUD_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
`endif

    if (QUIET_CYCLES < 1 || SETTLE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("baud_switch_ctrl: cycle-count parameters must be >= 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        APPLY,
        SETTLE,
`ifdef BAUD_CTRL_TIMEOUT_EN
        ABORT,
`endif
        ACK
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [1:0]      target;
    logic [QW-1:0]   quiet_cnt;
    logic [SW-1:0]   settle_cnt;
    logic            link_quiet;
    logic            accept;
`ifdef BAUD_CTRL_TIMEOUT_EN
    logic [TW-1:0]   drain_cnt;
`endif

    assign link_quiet = !tx_busy && !rx_busy;
    assign accept     = req_valid && (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_next = (req_sel == baud_sel) ? ACK : DRAIN;
                end
            end
            DRAIN: begin
                // Quiet completion wins over a timeout landing on the same cycle.
                if (link_quiet && quiet_cnt == QW'(QUIET_CYCLES - 1)) begin
                    state_next = APPLY;
                end
`ifdef BAUD_CTRL_TIMEOUT_EN
                else if (drain_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_next = ABORT;
                end
`endif
            end
            APPLY:  state_next = SETTLE;
            SETTLE: begin
                if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
                    state_next = ACK;
                end
            end
            ACK:    state_next = IDLE;
`ifdef BAUD_CTRL_TIMEOUT_EN
            ABORT:  state_next = IDLE;
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target   <= RESET_SEL;
            baud_sel <= RESET_SEL;
        end else begin
            if (accept) begin
                target <= req_sel;
            end
            if (state == APPLY) begin
                baud_sel <= target;
            end
        end
    end

    // Counters are zero outside their own state, so every entry starts from a clean count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quiet_cnt  <= '0;
            settle_cnt <= '0;
        end else begin
            if (state != DRAIN || !link_quiet) begin
                quiet_cnt <= '0;
            end else if (quiet_cnt != QW'(QUIET_CYCLES)) begin
                quiet_cnt <= quiet_cnt + 1'b1;
            end
            if (state != SETTLE) begin
                settle_cnt <= '0;
            end else if (settle_cnt != SW'(SETTLE_CYCLES)) begin
                settle_cnt <= settle_cnt + 1'b1;
            end
        end
    end

`ifdef BAUD_CTRL_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drain_cnt <= '0;
        end else if (state != DRAIN) begin
            drain_cnt <= '0;
        end else if (drain_cnt != TW'(TIMEOUT_CYCLES)) begin
            drain_cnt <= drain_cnt + 1'b1;
        end
    end

    assign err = (state == ABORT);
`else
    assign err = 1'b0;
`endif

    assign req_ready = (state == IDLE);
    assign hold      = (state == DRAIN) || (state == APPLY) || (state == SETTLE);
    assign done      = (state == ACK);

endmodule

// File: tb/tb_baud_switch_ctrl.sv
// Randomized self-checking bench for baud_switch_ctrl: each request's timeline is predicted
// from the busy schedule (first quiet window, fixed settle length) and compared cycle by cycle.
module tb_baud_switch_ctrl;

    localparam int Q = 4;
    localparam int S = 8;
    localparam int T = 32;
    localparam int N = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic [1:0] req_sel;
    logic       req_ready;
    logic       tx_busy;
    logic       rx_busy;
    logic       hold;
    logic [1:0] baud_sel;
    logic       done;
    logic       err;

    int         checks = 0;
    int         errors = 0;
    logic [1:0] cur_sel;
    logic       tx_arr [N];
    logic       rx_arr [N];

    always #10 clk = ~clk;

    baud_switch_ctrl #(
        .RESET_SEL(2'b00),
        .QUIET_CYCLES(Q),
        .SETTLE_CYCLES(S),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_sel(req_sel),
        .req_ready(req_ready),
        .tx_busy(tx_busy),
        .rx_busy(rx_busy),
        .hold(hold),
        .baud_sel(baud_sel),
        .done(done),
        .err(err)
    );

    task automatic checkOutput(input string tag, input logic [1:0] observed, input logic [1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0b expected %0b", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input int k, input logic [1:0] e_sel, input logic e_hold,
                            input logic e_done, input logic e_err, input logic e_ready);
        checkOutput($sformatf("%s k=%0d baud_sel", tag, k), baud_sel, e_sel);
        checkOutput($sformatf("%s k=%0d hold", tag, k), {1'b0, hold}, {1'b0, e_hold});
        checkOutput($sformatf("%s k=%0d done", tag, k), {1'b0, done}, {1'b0, e_done});
        checkOutput($sformatf("%s k=%0d err", tag, k), {1'b0, err}, {1'b0, e_err});
        checkOutput($sformatf("%s k=%0d req_ready", tag, k), {1'b0, req_ready}, {1'b0, e_ready});
    endtask

    // Cycle index (relative to acceptance) at which QUIET_CYCLES consecutive idle cycles complete.
    function automatic int findQuiet(input int limit);
        int run = 0;
        for (int k = 1; k <= limit && k < N; k++) begin
            run = (tx_arr[k] || rx_arr[k]) ? 0 : run + 1;
            if (run == Q) return k;
        end
        return -1;
    endfunction

    // mode: 0 idle link, 1 random busy, 2 tx burst plus rx glitch, 3 rx stuck busy
    task automatic fillBusy(input int mode);
        int burst_len = $urandom_range(0, 20);
        for (int k = 0; k < N; k++) begin
            logic [1:0] kind = 2'b00;
            case (mode)
                1: if (k > 0 && (k <= burst_len || k > burst_len + Q) && $urandom_range(9) < 4)
                       kind = 2'($urandom_range(1, 3));
                2: begin
                    if (k >= 1 && k <= 10) kind = 2'b01;
                    if (k == 12) kind = 2'b10;
                end
                3: if (k > 0) kind = 2'b10;
                default: kind = 2'b00;
            endcase
            tx_arr[k] = kind[0];
            rx_arr[k] = kind[1];
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [1:0] sel, input int mode, input int reset_at);
        int e;
        int limit;
        int done_at;
        int err_at;
        int hold_last;
        int ready_from;
        int switch_at;
        int last_k;
        fillBusy(mode);
`ifdef BAUD_CTRL_TIMEOUT_EN
        limit = T;
`else
        limit = N - 1;
`endif
        if (sel == cur_sel) begin
            done_at = 1; err_at = -1; hold_last = 0; ready_from = 2; switch_at = N + 1; last_k = 2;
        end else begin
            e = findQuiet(limit);
            if (e < 0) begin
                done_at = -1; err_at = limit + 1; hold_last = limit;
                ready_from = limit + 2; switch_at = N + 1; last_k = limit + 2;
            end else begin
                done_at = e + S + 2; err_at = -1; hold_last = e + S + 1;
                ready_from = e + S + 3; switch_at = e + 2; last_k = e + S + 3;
            end
        end

        req_valid = 1'b1;
        req_sel   = sel;
        tx_busy   = 1'b0;
        rx_busy   = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_sel   = 2'($urandom);

        for (int k = 1; k <= last_k; k++) begin
            if (k == reset_at) begin
                rst = 1'b1;
                #1;
                checkAll({tag, " async_rst"}, k, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
                @(posedge clk); #1;
                rst = 1'b0;
                cur_sel = 2'b00;
                for (int j = 0; j < 4; j++) begin
                    checkAll({tag, " post_rst"}, j, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
                    @(posedge clk); #1;
                end
                return;
            end
            checkAll(tag, k, (k >= switch_at) ? sel : cur_sel, k <= hold_last,
                     k == done_at, k == err_at, k >= ready_from);
            tx_busy = (k < N) ? tx_arr[k] : 1'b0;
            rx_busy = (k < N) ? rx_arr[k] : 1'b0;
            if (k < last_k) begin
                @(posedge clk); #1;
            end
        end
        if (done_at > 0) cur_sel = sel;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_sel   = 2'b00;
        tx_busy   = 1'b0;
        rx_busy   = 1'b0;
        cur_sel   = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkAll("reset", 0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);

        applyStimulus("same_sel", 2'b00, 0, 0);
        applyStimulus("idle_to_11", 2'b11, 0, 0);
        applyStimulus("busy_to_10", 2'b10, 2, 0);
        applyStimulus("same_sel_10", 2'b10, 1, 0);
        applyStimulus("idle_to_00", 2'b00, 0, 0);
        applyStimulus("rst_in_settle", 2'b01, 0, 9);
        applyStimulus("after_rst", 2'b01, 0, 0);
`ifdef BAUD_CTRL_TIMEOUT_EN
        applyStimulus("timeout_to_11", 2'b11, 3, 0);
`endif
        for (int i = 0; i < 20; i++) begin
            applyStimulus($sformatf("rand%0d", i), 2'($urandom), 1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
